// File: rtl/noc_pkg.sv
// Shared constants for the neuromorphic NoC mesh:
// link directions, default packet width and spike packet fields.
package noc_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    localparam int N = int'(DIR_N);
    localparam int E = int'(DIR_E);
    localparam int S = int'(DIR_S);
    localparam int W = int'(DIR_W);

    localparam int DATA_WIDTH_DEF = 32;

    // Spike packet: {dst_row, dst_col, weight, neuron_id}
    localparam int PKT_NID_LSB = 0;
    localparam int PKT_NID_W   = 8;
    localparam int PKT_WGT_LSB = 8;
    localparam int PKT_WGT_W   = 8;
    localparam int PKT_COL_LSB = 16;
    localparam int PKT_ROW_LSB = 24;
    localparam int PKT_POS_W   = 8;

    localparam logic [15:0] SPIKE_THRESH = 16'd256;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [6:0]  OPC_LOAD     = 7'b000_0011;

    function automatic int opp(input int d);
        return (d + 2) % 4;
    endfunction

endpackage

// File: rtl/noc_mesh_if.sv
// Valid/ready packet channel between a node port and a mesh link.
interface noc_mesh_if
    import noc_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mesh_link.sv
// One-entry registered link stage; accepts a new packet in the same
// cycle the held one drains, so a ready downstream sees no bubble.
module mesh_link
    import noc_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) (
    input logic         clk,
    input logic         rst_n,
    noc_mesh_if.slave   up,
    noc_mesh_if.master  dn
);
    logic          r_full;
    logic [DW-1:0] r_data;

    assign up.ready = !r_full || dn.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (up.valid && up.ready) begin
            r_full <= 1'b1;
            r_data <= up.data;
        end else if (dn.ready) begin
            r_full <= 1'b0;
        end
    end

    assign dn.valid = r_full;
    assign dn.data  = r_data;
endmodule

// File: rtl/noc_node.sv
// Processing node: CPU front end, instruction/data memory status and a
// bank of integrate-and-fire neurons fed by addressed spike packets.
module noc_node
    import noc_pkg::*;
#(
    parameter int ROW_ID      = 0,
    parameter int COL_ID      = 0,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_NEURONS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_n,
    input  logic                  in_valid_e,
    input  logic                  in_valid_s,
    input  logic                  in_valid_w,
    input  logic [DATA_WIDTH-1:0] in_data_n,
    input  logic [DATA_WIDTH-1:0] in_data_e,
    input  logic [DATA_WIDTH-1:0] in_data_s,
    input  logic [DATA_WIDTH-1:0] in_data_w,
    input  logic                  out_ready_n,
    input  logic                  out_ready_e,
    input  logic                  out_ready_s,
    input  logic                  out_ready_w,
    output logic                  in_ready_n,
    output logic                  in_ready_e,
    output logic                  in_ready_s,
    output logic                  in_ready_w,
    output logic                  out_valid_n,
    output logic                  out_valid_e,
    output logic                  out_valid_s,
    output logic                  out_valid_w,
    output logic [DATA_WIDTH-1:0] out_data_n,
    output logic [DATA_WIDTH-1:0] out_data_e,
    output logic [DATA_WIDTH-1:0] out_data_s,
    output logic [DATA_WIDTH-1:0] out_data_w
);
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_mem_busywait;
    logic        data_mem_busywait;

    assign instruction        = NOP_INSTR;
    assign instr_mem_busywait = 1'b0;
    assign data_mem_busywait  = 1'b0;

    node_cpu CPU (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_instr     (instruction),
        .i_imem_busy (instr_mem_busywait),
        .i_dmem_busy (data_mem_busywait),
        .o_pc        (pc)
    );

    logic [3:0]            w_vld;
    logic [3:0]            w_hit;
    logic [DATA_WIDTH-1:0] w_dat [4];

    assign w_vld    = {in_valid_w, in_valid_s, in_valid_e, in_valid_n};
    assign w_dat[N] = in_data_n;
    assign w_dat[E] = in_data_e;
    assign w_dat[S] = in_data_s;
    assign w_dat[W] = in_data_w;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = w_vld[k] &&
                (w_dat[k][PKT_ROW_LSB +: PKT_POS_W] == PKT_POS_W'(ROW_ID)) &&
                (w_dat[k][PKT_COL_LSB +: PKT_POS_W] == PKT_POS_W'(COL_ID));
        end
    end

    logic [15:0]            r_pot [NUM_NEURONS];
    logic [15:0]            w_pot_nxt [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_fired;
    logic [NUM_NEURONS-1:0] w_fire;

    // Every port may hit the same neuron in one cycle; weights accumulate
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            w_pot_nxt[i] = r_pot[i];
            w_fire[i]    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (w_hit[k] &&
                    w_dat[k][PKT_NID_LSB +: PKT_NID_W] == PKT_NID_W'(i))
                    w_pot_nxt[i] = w_pot_nxt[i] +
                        16'(w_dat[k][PKT_WGT_LSB +: PKT_WGT_W]);
            end
            if (w_pot_nxt[i] >= SPIKE_THRESH) begin
                w_fire[i]    = 1'b1;
                w_pot_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= '0;
            r_fired <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= w_pot_nxt[i];
            r_fired <= w_fire;
        end
    end

    assign in_ready_n  = 1'b1;
    assign in_ready_e  = 1'b1;
    assign in_ready_s  = 1'b1;
    assign in_ready_w  = 1'b1;
    assign out_valid_n = 1'b0;
    assign out_valid_e = 1'b0;
    assign out_valid_s = 1'b0;
    assign out_valid_w = 1'b0;
    assign out_data_n  = '0;
    assign out_data_e  = '0;
    assign out_data_s  = '0;
    assign out_data_w  = '0;

    logic w_unused;
    assign w_unused = &{1'b0, out_ready_n, out_ready_e, out_ready_s,
                        out_ready_w, r_fired, pc};
endmodule

// File: rtl/node_cpu.sv
// Minimal in-order fetch front end of a node CPU with
// load-use hazard detection against the IF/ID instruction.
module node_cpu
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_imem_busy,
    input  logic        i_dmem_busy,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    logic [31:0] r_ifid;
    logic        ID_LU_HAZ_SIG;
    logic [4:0]  w_rd;
    logic        w_busy;

    assign w_rd   = r_ifid[11:7];
    assign w_busy = i_imem_busy || i_dmem_busy;

    assign ID_LU_HAZ_SIG = (r_ifid[6:0] == OPC_LOAD) && (w_rd != 5'd0) &&
                           ((w_rd == i_instr[19:15]) || (w_rd == i_instr[24:20]));

    // A hazard holds the pc and injects a bubble into IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_ifid <= NOP_INSTR;
        end else if (!w_busy) begin
            if (ID_LU_HAZ_SIG) begin
                r_ifid <= NOP_INSTR;
            end else begin
                r_pc   <= r_pc + 32'd4;
                r_ifid <= i_instr;
            end
        end
    end

    assign o_pc = r_pc;

    logic w_unused;
    assign w_unused = &{1'b0, i_instr[31:25], i_instr[14:0], r_ifid[31:12]};
endmodule

// File: rtl/noc_mesh.sv
// ROWS x COLS grid of noc_node instances joined by one mesh_link per
// direction per neighbouring pair; off-grid ports are tied off.
module noc_mesh
    import noc_pkg::*;
#(
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_NEURONS = 4
) (
    input logic clk,
    input logic rst
);
    logic                  w_in_valid  [ROWS][COLS][4];
    logic [DATA_WIDTH-1:0] w_in_data   [ROWS][COLS][4];
    logic                  w_in_ready  [ROWS][COLS][4];
    logic                  w_out_valid [ROWS][COLS][4];
    logic [DATA_WIDTH-1:0] w_out_data  [ROWS][COLS][4];
    logic                  w_out_ready [ROWS][COLS][4];

    for (genvar r = 0; r < ROWS; r++) begin : ROW_LOOP
        for (genvar c = 0; c < COLS; c++) begin : COL_LOOP
            // Each cell owns the links leaving it and feeds the neighbour
            for (genvar d = 0; d < 4; d++) begin : DIR_LOOP
                localparam bit HAS = (d == N) ? (r > 0) :
                                     (d == E) ? (c < COLS - 1) :
                                     (d == S) ? (r < ROWS - 1) : (c > 0);
                localparam int NR = (d == N) ? r - 1 : (d == S) ? r + 1 : r;
                localparam int NC = (d == W) ? c - 1 : (d == E) ? c + 1 : c;
                localparam int OD = opp(d);
                if (HAS) begin : G_LINK
                    noc_mesh_if #(.DW(DATA_WIDTH)) u_up ();
                    noc_mesh_if #(.DW(DATA_WIDTH)) u_dn ();
                    assign u_up.valid           = w_out_valid[r][c][d];
                    assign u_up.data            = w_out_data[r][c][d];
                    assign w_out_ready[r][c][d] = u_up.ready;
                    assign u_dn.ready           = w_in_ready[NR][NC][OD];
                    assign w_in_valid[NR][NC][OD] = u_dn.valid;
                    assign w_in_data[NR][NC][OD]  = u_dn.data;
                    mesh_link #(.DW(DATA_WIDTH)) u_link (
                        .clk   (clk),
                        .rst_n (rst),
                        .up    (u_up.slave),
                        .dn    (u_dn.master)
                    );
                end else begin : G_EDGE
                    assign w_in_valid[r][c][d]  = 1'b0;
                    assign w_in_data[r][c][d]   = '0;
                    assign w_out_ready[r][c][d] = 1'b1;
                end
            end

            noc_node #(
                .ROW_ID      (r),
                .COL_ID      (c),
                .DATA_WIDTH  (DATA_WIDTH),
                .NUM_NEURONS (NUM_NEURONS)
            ) u_node (
                .clk         (clk),
                .rst_n       (rst),
                .in_valid_n  (w_in_valid[r][c][N]),
                .in_valid_e  (w_in_valid[r][c][E]),
                .in_valid_s  (w_in_valid[r][c][S]),
                .in_valid_w  (w_in_valid[r][c][W]),
                .in_data_n   (w_in_data[r][c][N]),
                .in_data_e   (w_in_data[r][c][E]),
                .in_data_s   (w_in_data[r][c][S]),
                .in_data_w   (w_in_data[r][c][W]),
                .out_ready_n (w_out_ready[r][c][N]),
                .out_ready_e (w_out_ready[r][c][E]),
                .out_ready_s (w_out_ready[r][c][S]),
                .out_ready_w (w_out_ready[r][c][W]),
                .in_ready_n  (w_in_ready[r][c][N]),
                .in_ready_e  (w_in_ready[r][c][E]),
                .in_ready_s  (w_in_ready[r][c][S]),
                .in_ready_w  (w_in_ready[r][c][W]),
                .out_valid_n (w_out_valid[r][c][N]),
                .out_valid_e (w_out_valid[r][c][E]),
                .out_valid_s (w_out_valid[r][c][S]),
                .out_valid_w (w_out_valid[r][c][W]),
                .out_data_n  (w_out_data[r][c][N]),
                .out_data_e  (w_out_data[r][c][E]),
                .out_data_s  (w_out_data[r][c][S]),
                .out_data_w  (w_out_data[r][c][W])
            );
        end
    end
endmodule

// File: tb/tb_noc_mesh.sv
// Directed checks of boot, link latency, backpressure, edge tie-off,
// bidirectional exchange and reset of in-flight link contents.
`define NODE(r, c) dut.ROW_LOOP[r].COL_LOOP[c].u_node

module tb_noc_mesh;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    noc_mesh #(
        .ROWS        (3),
        .COLS        (3),
        .DATA_WIDTH  (32),
        .NUM_NEURONS (4)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;

        // Boot
        @(negedge clk);
        check("rst_pc00_a", `NODE(0,0).pc, 32'd0);
        check("rst_pc11_a", `NODE(1,1).pc, 32'd0);
        check("rst_link_empty", `NODE(0,1).in_valid_w, 1'b0);
        @(negedge clk);
        check("rst_pc00_b", `NODE(0,0).pc, 32'd0);
        check("rst_pc11_b", `NODE(1,1).pc, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("boot_pc00_4", `NODE(0,0).pc, 32'd4);
        check("boot_pc11_4", `NODE(1,1).pc, 32'd4);
        @(negedge clk);
        check("boot_pc00_8", `NODE(0,0).pc, 32'd8);
        check("boot_pc11_8", `NODE(1,1).pc, 32'd8);
        check("boot_no_haz", `NODE(1,1).CPU.ID_LU_HAZ_SIG, 1'b0);

        // Link latency (0,0) east -> (0,1) west
        force `NODE(0,0).out_valid_e = 1'b1;
        force `NODE(0,0).out_data_e  = 32'hDEADBEEF;
        #1 check("lat_not_yet", `NODE(0,1).in_valid_w, 1'b0);
        @(negedge clk);
        release `NODE(0,0).out_valid_e;
        release `NODE(0,0).out_data_e;
        check("lat_valid", `NODE(0,1).in_valid_w, 1'b1);
        check("lat_data", `NODE(0,1).in_data_w, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_one_cycle", `NODE(0,1).in_valid_w, 1'b0);

        // Backpressure (0,1) south -> (1,1) north
        force `NODE(1,1).in_ready_n  = 1'b0;
        force `NODE(0,1).out_valid_s = 1'b1;
        force `NODE(0,1).out_data_s  = 32'h1;
        #1 check("bp_empty_ready", `NODE(0,1).out_ready_s, 1'b1);
        @(negedge clk);
        check("bp_hold_valid", `NODE(1,1).in_valid_n, 1'b1);
        check("bp_hold_data", `NODE(1,1).in_data_n, 32'h1);
        check("bp_up_stall", `NODE(0,1).out_ready_s, 1'b0);
        force `NODE(0,1).out_data_s = 32'h2;
        @(negedge clk);
        check("bp_still_data", `NODE(1,1).in_data_n, 32'h1);
        check("bp_still_stall", `NODE(0,1).out_ready_s, 1'b0);
        release `NODE(1,1).in_ready_n;
        #1 check("bp_release_ready", `NODE(0,1).out_ready_s, 1'b1);
        @(negedge clk);
        release `NODE(0,1).out_valid_s;
        release `NODE(0,1).out_data_s;
        check("bp_second_valid", `NODE(1,1).in_valid_n, 1'b1);
        check("bp_second_data", `NODE(1,1).in_data_n, 32'h2);
        @(negedge clk);
        check("bp_drained", `NODE(1,1).in_valid_n, 1'b0);

        // Edge tie-off at (0,0)
        force `NODE(0,0).out_valid_n = 1'b1;
        force `NODE(0,0).out_data_n  = 32'h12345678;
        #1 check("edge_ready_n", `NODE(0,0).out_ready_n, 1'b1);
        check("edge_ready_w", `NODE(0,0).out_ready_w, 1'b1);
        @(negedge clk);
        release `NODE(0,0).out_valid_n;
        release `NODE(0,0).out_data_n;
        check("edge_in_valid_n", `NODE(0,0).in_valid_n, 1'b0);
        check("edge_in_valid_w", `NODE(0,0).in_valid_w, 1'b0);
        check("edge_in_data_n", `NODE(0,0).in_data_n, 32'h0);

        // Bidirectional exchange between (1,0) and (1,1)
        force `NODE(1,0).out_valid_e = 1'b1;
        force `NODE(1,0).out_data_e  = 32'hA;
        force `NODE(1,1).out_valid_w = 1'b1;
        force `NODE(1,1).out_data_w  = 32'hB;
        @(negedge clk);
        release `NODE(1,0).out_valid_e;
        release `NODE(1,0).out_data_e;
        release `NODE(1,1).out_valid_w;
        release `NODE(1,1).out_data_w;
        check("bidir_e_valid", `NODE(1,1).in_valid_w, 1'b1);
        check("bidir_e_data", `NODE(1,1).in_data_w, 32'hA);
        check("bidir_w_valid", `NODE(1,0).in_valid_e, 1'b1);
        check("bidir_w_data", `NODE(1,0).in_data_e, 32'hB);
        @(negedge clk);
        check("bidir_e_done", `NODE(1,1).in_valid_w, 1'b0);
        check("bidir_w_done", `NODE(1,0).in_valid_e, 1'b0);

        // Reset with (1,2) west -> (1,1) east link full
        force `NODE(1,2).out_valid_w = 1'b1;
        force `NODE(1,2).out_data_w  = 32'h55;
        @(negedge clk);
        release `NODE(1,2).out_valid_w;
        release `NODE(1,2).out_data_w;
        check("mid_full", `NODE(1,1).in_valid_e, 1'b1);
        rst = 1'b0;
        #1 check("mid_async_clear", `NODE(1,1).in_valid_e, 1'b0);
        check("mid_data_clear", `NODE(1,1).in_data_e, 32'h0);
        check("mid_pc_clear", `NODE(1,1).pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_none_a", `NODE(1,1).in_valid_e, 1'b0);
        check("post_rst_pc", `NODE(1,1).pc, 32'd4);
        @(negedge clk);
        check("post_rst_none_b", `NODE(1,1).in_valid_e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`undef NODE

// File: doc/noc_mesh.md
# noc_mesh

Structural top of the neuromorphic NoC accelerator. It instantiates a ROWS×COLS grid of processing nodes; each node holds a CPU, instruction/data memories and NUM_NEURONS neurons. Neighbouring nodes are connected by one-entry registered links carrying DATA_WIDTH-bit spike packets. The block has no external data ports; all activity is internal and is observed hierarchically.

## Interface
- ROWS, 3, number of grid rows (≥1)
- COLS, 3, number of grid columns (≥1)
- DATA_WIDTH, 32, packet width in bits
- NUM_NEURONS, 4, neurons per node (passed through to each node)

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset, broadcast to every node and link

## Operation
- Generate loops are labelled ROW_LOOP[r] and COL_LOOP[c]. The node instance in each cell is named u_node, so probes such as ROW_LOOP[1].COL_LOOP[1].u_node.pc resolve.
- Each node exposes pc, instruction, instr_mem_busywait and data_mem_busywait. Its CPU instance is named CPU and contains ID_LU_HAZ_SIG.
- Node parameters: ROW_ID=r, COL_ID=c, DATA_WIDTH, NUM_NEURONS.
- Each node has 4 directions d ∈ {n,e,s,w}. Per direction:
  - inputs: in_valid_d, in_data_d[DATA_WIDTH-1:0], out_ready_d
  - outputs: in_ready_d, out_valid_d, out_data_d
- Orientation: row 0 is north, col 0 is west.
  - N neighbour of (r,c) is (r-1,c); S is (r+1,c); E is (r,c+1); W is (r,c-1).
- Links: one link instance per direction per adjacent pair, i.e. 2·(ROWS·(COLS-1) + COLS·(ROWS-1)) links.
  - Example: the link (r,c).out_e → (r,c+1).in_w.
- Each link is a one-entry register with fields full and data:
  - up_ready = !full || down_ready
  - on up_valid && up_ready: load data, set full
  - else if down_ready: clear full
  - down_valid = full; down_data = data
- Edge tie-off for a direction with no neighbour:
  - node in_valid=0, in_data=0
  - node out_ready=1; packets sent off-grid are silently dropped
- Routing and packet format belong to the node, not this block. The mesh is transparent to packet contents.

## Timing
- While rst=0: every link's full clears immediately (asynchronous). Node reset is per the node spec (pc=0).
- On the first rising edge after rst rises, nodes begin fetching.
- Link latency:
  - A packet accepted at edge k is visible at the downstream in_valid during cycle k+1.
  - Throughput is 1 packet/cycle when downstream is ready.
- Backpressure: when full=1 and down_ready=0, up_ready=0 and data holds stable.
- Simultaneous accept and drain in the same cycle keeps full=1 with the new data. No bubble is inserted.
- Opposite-direction links are independent, so simultaneous exchange between two nodes never conflicts.
- Reset asserted mid-transfer discards all in-flight link contents.

## Structure
- Shared package noc_pkg holds:
  - direction indices N=0, E=1, S=2, W=3
  - the DATA_WIDTH default
  - the packet field constants used by the node
- One sub-module: mesh_link (the one-entry register stage described above).
- The node module is existing; this block only instantiates it.

## Test plan
- Reset/boot:
  - Stimulus: hold rst=0 for 2 cycles, then release.
  - Required: node(0,0).pc=0 during reset; after release, pc advances (0→4→8 absent stalls). Node(1,1) behaves identically.
- Link latency:
  - Stimulus: force node(0,0).out_valid_e=1 with data 0xDEADBEEF for one cycle.
  - Required: node(0,1).in_valid_w=1 and in_data_w=0xDEADBEEF exactly one cycle later, for one cycle.
- Backpressure:
  - Stimulus: hold node(1,1).in_ready_n=0 and send 2 packets (0x1, 0x2) from node(0,1) south.
  - Required: link holds 0x1 and upstream out_ready_s=0.
  - Then release ready: 0x1 is delivered, then 0x2 the next cycle, with no loss or duplication.
- Edge tie-off:
  - Stimulus: node(0,0) drives out_valid_n=1.
  - Required: out_ready_n=1 and the packet is dropped. Node(0,0).in_valid_n and in_valid_w stay 0.
- Bidirectional exchange:
  - Stimulus: node(1,0) sends 0xA east while node(1,1) sends 0xB west in the same cycle.
  - Required: both arrive one cycle later.
- Reset mid-flight:
  - Stimulus: assert rst with a link full.
  - Required: down_valid drops to 0 immediately, and no packet is delivered after reset release.
